fetch_stall_ctrl: RTL and testbench
===================================

// Module: fetch_stall_ctrl
// PURPOSE
//   Consumer end of the load-use hazard handshake. Holds the PC and the IF/ID pipeline register.
//   Applies PC_write / IFID_write / ID_Flush_stall from hazard detection, plus the EX-stage branch redirect.
//   Generates the ID/EX valid (bubble) bit.
//   Tracks stall/flush state, keeps performance counters and flags handshake violations.
// PARAMETERS
//   XLEN       64            PC / address width
//   RESET_PC   0             PC value loaded on reset
//   NOP_INSTR  32'h00000013  encoding inserted into IF/ID on flush (addi x0,x0,0)
//   MAX_STALL  4             consecutive stall cycles before stall_timeout sets
//   CNT_W      32            width of stall_count / flush_count
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous reset, active low (asserted when reset==0)
//   PC_write       in   1      1 = PC may advance; 0 = hold PC
//   IFID_write     in   1      1 = IF/ID may load; 0 = hold IF/ID
//   ID_Flush_stall in   1      1 = insert bubble into ID/EX this cycle
//   branch_taken   in   1      EX-stage redirect request
//   branch_target  in   XLEN   redirect PC, valid when branch_taken=1
//   instr_in       in   32     instruction fetched at pc_out (combinational imem)
//   pc_out         out  XLEN   current fetch PC
//   IFID_pc        out  XLEN   PC of instruction in IF/ID
//   IFID_instr     out  32     instruction in IF/ID
//   IFID_valid     out  1      IF/ID holds a real instruction
//   IDEX_valid     out  1      registered; 0 = ID/EX carries a bubble
//   stall_active   out  1      FSM in STALL
//   stall_count    out  CNT_W  cycles with a stall applied (saturating)
//   flush_count    out  CNT_W  branch flushes taken (saturating)
//   stall_timeout  out  1      sticky: stall held more than MAX_STALL consecutive cycles
//   protocol_err   out  1      sticky: PC_write != IFID_write, or ID_Flush_stall != ~PC_write
// BEHAVIOUR
//   Reset values (posedge clk with reset==0): pc_out=RESET_PC, IFID_pc=0, IFID_instr=NOP_INSTR.
//     All other outputs reset to 0; FSM enters RUN. Reset mid-stall or mid-flush discards all state.
//   Stall condition: stall = ~PC_write & ~branch_taken.
//   PC update, priority order:
//     branch_taken: pc <= branch_target
//     else PC_write: pc <= pc+4 (mod 2^XLEN, wraps silently)
//     else: hold
//   IF/ID update, priority order:
//     branch_taken: IFID_instr <= NOP_INSTR, IFID_valid <= 0, IFID_pc <= 0
//     else IFID_write: load instr_in, pc_out; IFID_valid <= 1
//     else: hold all three
//   Branch beats stall: the branch is older than the stalled load consumer.
//   IDEX_valid <= (ID_Flush_stall | branch_taken) ? 0 : IFID_valid. Latency 1 cycle.
//   FSM (registered, next state evaluated every cycle):
//     RUN   -> FLUSH on branch_taken; -> STALL on stall; else RUN
//     STALL -> FLUSH on branch_taken; stay STALL on stall; else RUN
//     FLUSH -> FLUSH on branch_taken; -> STALL on stall; else RUN (FLUSH lasts one cycle unless re-triggered)
//   stall_run counter: counts consecutive STALL cycles and clears on leaving STALL.
//     stall_timeout sets when stall_run reaches MAX_STALL with stall still high. Clears only on reset.
//   Counters: stall_count +1 per cycle where stall=1; flush_count +1 per cycle where branch_taken=1.
//     Both saturate at all-ones.
//   protocol_err: checked every non-reset cycle; sticky until reset.
//     ID_Flush_stall=1 together with branch_taken=1 is legal and is not an error.
// TESTING
//   Reset: reset=0 for 2 cycles -> pc_out=0, IFID_instr=0x00000013, IFID_valid=0, IDEX_valid=0, counters 0.
//   Free run: PC_write=IFID_write=1, ID_Flush_stall=0 for 3 cycles -> pc_out 0->4->8->12, IFID_pc lags by one.
//   Load-use: 1-cycle stall at pc_out=8 -> pc_out, IFID hold; next IDEX_valid=0.
//     Then stall_active=1 for 1 cycle, stall_count=1, no error.
//   Branch over stall: branch_taken=1, target=0x100, PC_write=0 same cycle -> pc_out=0x100, IFID_valid=0.
//     Also FSM=FLUSH, flush_count=1, stall_count unchanged.
//   Timeout/wrap: stall held 5 cycles -> stall_timeout=1 sticky.
//     Separately, RESET_PC=2^XLEN-4 -> pc_out wraps to 0.
//     Separately, PC_write=1 with IFID_write=0 -> protocol_err=1.
//   Reset mid-stall: reset=0 during STALL -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - PC / IF-ID holder applying load-use stall, bubble and branch redirect
module fetch_stall_ctrl #(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013,
  parameter int              MAX_STALL = 4,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_write,
  input  logic             IFID_write,
  input  logic             ID_Flush_stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [31:0]      instr_in,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  IFID_pc,
  output logic [31:0]      IFID_instr,
  output logic             IFID_valid,
  output logic             IDEX_valid,
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             stall_timeout,
  output logic             protocol_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             stall;
  logic [RUN_W-1:0] stall_run;

  // A redirect from EX is older than the stalled consumer, so it overrides the stall.
  assign stall        = ~PC_write & ~branch_taken;
  assign stall_active = (state_q == ST_STALL);

  always_comb begin
    state_d = ST_RUN;
    if (branch_taken) begin
      state_d = ST_FLUSH;
    end else if (stall) begin
      state_d = ST_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      pc_out        <= RESET_PC;
      IFID_pc       <= '0;
      IFID_instr    <= NOP_INSTR;
      IFID_valid    <= 1'b0;
      IDEX_valid    <= 1'b0;
      stall_count   <= '0;
      flush_count   <= '0;
      stall_run     <= '0;
      stall_timeout <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (branch_taken) begin
        pc_out <= branch_target;
      end else if (PC_write) begin
        pc_out <= pc_out + XLEN'(4);
      end

      if (branch_taken) begin
        IFID_instr <= NOP_INSTR;
        IFID_valid <= 1'b0;
        IFID_pc    <= '0;
      end else if (IFID_write) begin
        IFID_instr <= instr_in;
        IFID_valid <= 1'b1;
        IFID_pc    <= pc_out;
      end

      IDEX_valid <= (ID_Flush_stall | branch_taken) ? 1'b0 : IFID_valid;

      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (branch_taken && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + CNT_W'(1);
      end

      // stall_run saturates at MAX_STALL; it is nonzero exactly while the FSM sits in STALL.
      if (!stall) begin
        stall_run <= '0;
      end else if (stall_run != RUN_W'(MAX_STALL)) begin
        stall_run <= stall_run + RUN_W'(1);
      end
      if (stall && (stall_run == RUN_W'(MAX_STALL))) begin
        stall_timeout <= 1'b1;
      end

      if ((PC_write != IFID_write) || (ID_Flush_stall != ~PC_write)) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - scenario and randomized checks of fetch_stall_ctrl against a reference model
module tb_fetch_stall_ctrl;

  localparam int          XLEN      = 64;
  localparam int          CNT_W     = 8;
  localparam int          MAX_STALL = 4;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic             clk = 1'b0;
  logic             rst_n, pw, ifw, fl, br;
  logic [XLEN-1:0]  tgt;
  logic [31:0]      instr_in;
  logic [XLEN-1:0]  pc_out, IFID_pc;
  logic [31:0]      IFID_instr;
  logic             IFID_valid, IDEX_valid, stall_active, stall_timeout, protocol_err;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stall_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .reset(rst_n), .PC_write(pw), .IFID_write(ifw), .ID_Flush_stall(fl),
    .branch_taken(br), .branch_target(tgt), .instr_in(instr_in),
    .pc_out(pc_out), .IFID_pc(IFID_pc), .IFID_instr(IFID_instr), .IFID_valid(IFID_valid),
    .IDEX_valid(IDEX_valid), .stall_active(stall_active), .stall_count(stall_count),
    .flush_count(flush_count), .stall_timeout(stall_timeout), .protocol_err(protocol_err)
  );

  function automatic logic [31:0] imem(input logic [XLEN-1:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  assign instr_in = imem(pc_out);

  // Reference model: architectural view of the fetch front end.
  logic [XLEN-1:0] m_pc, m_ifpc;
  logic [31:0]     m_ifinstr;
  logic            m_ifv, m_idexv, m_stalled_last, m_to, m_perr;
  int              m_sc, m_fc, m_consec;

  task automatic model_edge();
    logic stall;
    if (!rst_n) begin
      m_pc = '0; m_ifpc = '0; m_ifinstr = NOP; m_ifv = 0; m_idexv = 0;
      m_stalled_last = 0; m_to = 0; m_perr = 0; m_sc = 0; m_fc = 0; m_consec = 0;
    end else begin
      stall = !pw && !br;
      if (pw != ifw || fl == pw) m_perr = 1;
      m_idexv = (fl || br) ? 1'b0 : m_ifv;
      if (br) begin
        m_ifinstr = NOP; m_ifv = 0; m_ifpc = '0;
      end else if (ifw) begin
        m_ifinstr = imem(m_pc); m_ifv = 1; m_ifpc = m_pc;
      end
      if (br) m_pc = tgt;
      else if (pw) m_pc = m_pc + 64'd4;
      m_stalled_last = stall;
      if (stall && m_sc < (1 << CNT_W) - 1) m_sc++;
      if (br && m_fc < (1 << CNT_W) - 1) m_fc++;
      m_consec = stall ? m_consec + 1 : 0;
      if (m_consec > MAX_STALL) m_to = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hs(input logic p, input logic b, input logic [XLEN-1:0] t);
    pw = p; ifw = p; fl = ~p; br = b; tgt = t;
  endtask

  task automatic do_reset();
    rst_n = 0; hs(1'b1, 1'b0, '0);
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; hs(1'b0, 1'b0, '0);
    tick(); tick();
    n_cmp++; if (pc_out !== 64'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", pc_out); end
    n_cmp++; if (IFID_instr !== 32'h13) begin n_err++; $display("FAIL rst_instr got %h want 00000013", IFID_instr); end
    n_cmp++; if ({IFID_valid, IDEX_valid, stall_active, stall_timeout, protocol_err} !== 5'b0) begin
      n_err++; $display("FAIL rst_flags got %b want 00000", {IFID_valid, IDEX_valid, stall_active, stall_timeout, protocol_err}); end
    n_cmp++; if ({stall_count, flush_count, IFID_pc} !== '0) begin
      n_err++; $display("FAIL rst_counts got sc=%0d fc=%0d ifpc=%h want 0", stall_count, flush_count, IFID_pc); end
    rst_n = 1;
  endtask

  task automatic test_free_run();
    hs(1'b1, 1'b0, '0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++; if (pc_out !== 64'(4 * i)) begin n_err++; $display("FAIL free_pc[%0d] got %h want %h", i, pc_out, 64'(4 * i)); end
      n_cmp++; if (IFID_pc !== 64'(4 * (i - 1)) || IFID_valid !== 1'b1) begin
        n_err++; $display("FAIL free_ifid[%0d] got pc=%h v=%b want pc=%h v=1", i, IFID_pc, IFID_valid, 64'(4 * (i - 1))); end
    end
    n_cmp++; if (IFID_instr !== imem(64'h8)) begin n_err++; $display("FAIL free_instr got %h want %h", IFID_instr, imem(64'h8)); end
  endtask

  task automatic test_load_use();
    do_reset();
    hs(1'b1, 1'b0, '0); tick(); tick();
    hs(1'b0, 1'b0, '0); tick();
    n_cmp++; if (pc_out !== 64'h8 || IFID_pc !== 64'h4) begin
      n_err++; $display("FAIL lu_hold got pc=%h ifpc=%h want 8/4", pc_out, IFID_pc); end
    n_cmp++; if (IDEX_valid !== 1'b0 || stall_active !== 1'b1) begin
      n_err++; $display("FAIL lu_bubble got idex=%b sa=%b want 0/1", IDEX_valid, stall_active); end
    n_cmp++; if (stall_count !== 8'd1 || protocol_err !== 1'b0) begin
      n_err++; $display("FAIL lu_count got sc=%0d perr=%b want 1/0", stall_count, protocol_err); end
    hs(1'b1, 1'b0, '0); tick();
    n_cmp++; if (stall_active !== 1'b0 || pc_out !== 64'hc || IDEX_valid !== 1'b1) begin
      n_err++; $display("FAIL lu_resume got sa=%b pc=%h idex=%b want 0/c/1", stall_active, pc_out, IDEX_valid); end
  endtask

  task automatic test_branch_over_stall();
    hs(1'b0, 1'b1, 64'h100); tick();
    n_cmp++; if (pc_out !== 64'h100 || IFID_valid !== 1'b0 || IFID_instr !== NOP) begin
      n_err++; $display("FAIL br_redirect got pc=%h v=%b ins=%h want 100/0/%h", pc_out, IFID_valid, IFID_instr, NOP); end
    n_cmp++; if (flush_count !== 8'd1 || stall_count !== 8'd1 || stall_active !== 1'b0) begin
      n_err++; $display("FAIL br_counts got fc=%0d sc=%0d sa=%b want 1/1/0", flush_count, stall_count, stall_active); end
    n_cmp++; if (IDEX_valid !== 1'b0 || protocol_err !== 1'b0) begin
      n_err++; $display("FAIL br_flags got idex=%b perr=%b want 0/0", IDEX_valid, protocol_err); end
  endtask

  task automatic test_timeout();
    hs(1'b0, 1'b0, '0);
    for (int i = 1; i <= 4; i++) tick();
    n_cmp++; if (stall_timeout !== 1'b0 || stall_active !== 1'b1) begin
      n_err++; $display("FAIL to_early got to=%b sa=%b want 0/1", stall_timeout, stall_active); end
    tick();
    n_cmp++; if (stall_timeout !== 1'b1) begin n_err++; $display("FAIL to_set got %b want 1", stall_timeout); end
    hs(1'b1, 1'b0, '0); tick(); tick();
    n_cmp++; if (stall_timeout !== 1'b1 || stall_active !== 1'b0) begin
      n_err++; $display("FAIL to_sticky got to=%b sa=%b want 1/0", stall_timeout, stall_active); end
  endtask

  task automatic test_reset_mid_stall();
    hs(1'b0, 1'b0, '0); tick(); tick();
    rst_n = 0; tick();
    n_cmp++; if ({pc_out, IFID_pc, IFID_instr} !== {64'h0, 64'h0, NOP}) begin
      n_err++; $display("FAIL rms_regs got pc=%h ifpc=%h ins=%h want 0/0/%h", pc_out, IFID_pc, IFID_instr, NOP); end
    n_cmp++; if ({IFID_valid, IDEX_valid, stall_active, stall_timeout, protocol_err, stall_count, flush_count} !== '0) begin
      n_err++; $display("FAIL rms_state got v=%b idex=%b sa=%b to=%b perr=%b sc=%0d fc=%0d want zeros",
        IFID_valid, IDEX_valid, stall_active, stall_timeout, protocol_err, stall_count, flush_count); end
    rst_n = 1;
  endtask

  task automatic test_wrap();
    do_reset();
    hs(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC); tick();
    hs(1'b1, 1'b0, '0); tick();
    n_cmp++; if (pc_out !== 64'h0 || IFID_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_err++; $display("FAIL wrap got pc=%h ifpc=%h want 0/fffffffffffffffc", pc_out, IFID_pc); end
  endtask

  task automatic test_protocol();
    do_reset();
    pw = 1; ifw = 0; fl = 0; br = 0; tick();
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_set got %b want 1", protocol_err); end
    hs(1'b1, 1'b0, '0); tick();
    n_cmp++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b want 1", protocol_err); end
  endtask

  task automatic test_saturate();
    do_reset();
    hs(1'b0, 1'b0, '0);
    for (int i = 0; i < 260; i++) tick();
    n_cmp++; if (stall_count !== 8'hFF) begin n_err++; $display("FAIL sat_stall got %0d want 255", stall_count); end
    hs(1'b0, 1'b1, 64'h40);
    for (int i = 0; i < 260; i++) tick();
    n_cmp++; if (flush_count !== 8'hFF || stall_count !== 8'hFF) begin
      n_err++; $display("FAIL sat_flush got fc=%0d sc=%0d want 255/255", flush_count, stall_count); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      hs($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0, {$urandom, $urandom} & ~64'h3);
      if ($urandom_range(0, 60) == 0) ifw = ~ifw;
      tick();
      n_cmp++;
      if ({pc_out, IFID_pc, IFID_instr, IFID_valid, IDEX_valid, stall_active, stall_count, flush_count, stall_timeout, protocol_err}
          !== {m_pc, m_ifpc, m_ifinstr, m_ifv, m_idexv, m_stalled_last, 8'(m_sc), 8'(m_fc), m_to, m_perr}) begin
        n_err++;
        $display("FAIL rand[%0d] got pc=%h ifpc=%h ins=%h v=%b idex=%b sa=%b sc=%0d fc=%0d to=%b perr=%b want pc=%h ifpc=%h ins=%h v=%b idex=%b sa=%b sc=%0d fc=%0d to=%b perr=%b",
          i, pc_out, IFID_pc, IFID_instr, IFID_valid, IDEX_valid, stall_active, stall_count, flush_count, stall_timeout, protocol_err,
          m_pc, m_ifpc, m_ifinstr, m_ifv, m_idexv, m_stalled_last, m_sc, m_fc, m_to, m_perr);
      end
    end
  endtask

  initial begin
    rst_n = 0; hs(1'b0, 1'b0, '0);
    test_reset();
    test_free_run();
    test_load_use();
    test_branch_over_stall();
    test_timeout();
    test_reset_mid_stall();
    test_wrap();
    test_protocol();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
